// File: rtl/datapath_seq.sv
// Sequencer that drives the 4-bit ALU datapath through load A, load B, execute and capture.
// Optional macro DATAPATH_SEQ_ACCUM_EN adds cmd_acc: LOAD_A then takes A from the datapath feedback path.
module datapath_seq #(
   parameter int                  WIDTH       = 4,
   parameter int                  OP_W        = 3,
   parameter int                  EXEC_CYCLES = 1,
   parameter logic [OP_W-1:0]     OP_IDLE     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
`ifdef DATAPATH_SEQ_ACCUM_EN
   input  logic             cmd_acc,
`endif
   output logic [WIDTH-1:0] dados,
   output logic             sel21,
   output logic             sel12,
   output logic [OP_W-1:0]  operacao,
   input  logic [WIDTH-1:0] resultado,
   input  logic             carry_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

   state_t           state;
   logic [3:0]       cnt;
   logic [OP_W-1:0]  op_q;
   logic [WIDTH-1:0] b_q;
   logic             accept;

   // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
   // the producer holds its payload stable until that edge, ready may depend on the consumer.
   assign cmd_ready = (state == IDLE) || ((state == DONE) && res_ready);
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         op_q      <= OP_IDLE;
         b_q       <= '0;
         dados     <= '0;
         sel21     <= 1'b1;
         sel12     <= 1'b0;
         operacao  <= OP_IDLE;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_carry <= 1'b0;
      end else if (accept) begin
         // Outputs for LOAD_A are set on the accept edge so they are valid during LOAD_A.
         op_q      <= cmd_op;
         b_q       <= cmd_b;
         state     <= LOAD_A;
         res_valid <= 1'b0;
         sel12     <= 1'b0;
         operacao  <= OP_IDLE;
`ifdef DATAPATH_SEQ_ACCUM_EN
         if (cmd_acc) begin
            dados <= '0;
            sel21 <= 1'b1;
         end else begin
            dados <= cmd_a;
            sel21 <= 1'b0;
         end
`else
         dados <= cmd_a;
         sel21 <= 1'b0;
`endif
      end else begin
         case (state)
            LOAD_A: begin
               state <= LOAD_B;
               dados <= b_q;
               sel21 <= 1'b0;
               sel12 <= 1'b1;
            end
            LOAD_B: begin
               state    <= EXEC;
               dados    <= '0;
               sel21    <= 1'b1;
               sel12    <= 1'b0;
               operacao <= op_q;
               cnt      <= 4'd0;
            end
            EXEC: begin
               if (cnt == EXEC_LAST) begin
                  state     <= DONE;
                  res_data  <= resultado;
                  res_carry <= carry_out;
                  res_valid <= 1'b1;
                  operacao  <= OP_IDLE;
                  cnt       <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq with a small behavioural model of the 4-bit ALU datapath.
// Define DATAPATH_SEQ_ACCUM_EN to also exercise the accumulate path.
module tb_datapath_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
`ifdef DATAPATH_SEQ_ACCUM_EN
   logic       cmd_acc;
`endif
   logic [3:0] dados;
   logic       sel21;
   logic       sel12;
   logic [2:0] operacao;
   logic [3:0] resultado;
   logic       carry_out;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic       res_carry;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   datapath_seq dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
`ifdef DATAPATH_SEQ_ACCUM_EN
      .cmd_acc   (cmd_acc),
`endif
      .dados     (dados),
      .sel21     (sel21),
      .sel12     (sel12),
      .operacao  (operacao),
      .resultado (resultado),
      .carry_out (carry_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_carry (res_carry)
   );

   // Datapath model: registers A/B load from dados or from the result feedback register.
   logic [3:0] ra = 4'd0;
   logic [3:0] rb = 4'd0;
   logic [3:0] fb = 4'd0;
   logic [4:0] alu;

   always_comb begin
      alu = 5'd0;
      case (operacao)
         3'b010:  alu = {1'b0, ra} + {1'b0, rb};
         default: alu = 5'd0;
      endcase
   end
   assign resultado = alu[3:0];
   assign carry_out = alu[4];

   always @(posedge clk) begin
      if (!sel21) begin
         if (sel12) rb <= dados;
         else       ra <= dados;
      end else if (operacao != 3'b000) begin
         fb <= alu[3:0];
      end else if (!sel12) begin
         ra <= fb;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'b000;
      cmd_a     = 4'd0;
      cmd_b     = 4'd0;
      res_ready = 1'b0;
`ifdef DATAPATH_SEQ_ACCUM_EN
      cmd_acc   = 1'b0;
`endif
      step();
      step();
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_carry", res_carry, 0);
      chk("rst_dados", dados, 0);
      chk("rst_sel21", sel21, 1);
      chk("rst_sel12", sel12, 0);
      chk("rst_operacao", operacao, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      step();

      // 3 + 1 = 4, sequence of control outputs
      send(3'b010, 4'b0011, 4'b0001);
      step();
      cmd_valid = 1'b0;
      chk("t1_loada_dados", dados, 4'b0011);
      chk("t1_loada_sel21", sel21, 0);
      chk("t1_loada_sel12", sel12, 0);
      chk("t1_loada_ready", cmd_ready, 0);
      step();
      chk("t1_loadb_dados", dados, 4'b0001);
      chk("t1_loadb_sel21", sel21, 0);
      chk("t1_loadb_sel12", sel12, 1);
      step();
      chk("t1_exec_sel21", sel21, 1);
      chk("t1_exec_operacao", operacao, 3'b010);
      chk("t1_exec_res_valid", res_valid, 0);
      step();
      chk("t1_res_valid", res_valid, 1);
      chk("t1_res_data", res_data, 4'b0100);
      chk("t1_res_carry", res_carry, 0);
      chk("t1_done_operacao", operacao, 0);

      // Result back-pressure, with an ignored command pulse
      for (int i = 0; i < 5; i++) begin
         if (i == 2) send(3'b010, 4'b1001, 4'b0110);
         step();
         cmd_valid = 1'b0;
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_data", res_data, 4'b0100);
         chk("hold_res_carry", res_carry, 0);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_sel21", sel21, 1);
      end
      res_ready = 1'b1;
      #1;
      chk("done_ready_with_res_ready", cmd_ready, 1);
      step();
      chk("release_res_valid", res_valid, 0);
      chk("release_idle_ready", cmd_ready, 1);
      res_ready = 1'b0;

      // Carry out: 15 + 1
      send(3'b010, 4'b1111, 4'b0001);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      step();
      chk("t2_res_valid", res_valid, 1);
      chk("t2_res_data", res_data, 4'b0000);
      chk("t2_res_carry", res_carry, 1);
      res_ready = 1'b1;
      step();
      chk("t2_release", res_valid, 0);

      // Back-to-back: 2+5 then 6+6, second accepted in the DONE cycle
      send(3'b010, 4'b0010, 4'b0101);
      step();
      send(3'b010, 4'b0110, 4'b0110);
      step();
      step();
      step();
      chk("b2b_first_valid", res_valid, 1);
      chk("b2b_first_data", res_data, 4'b0111);
      chk("b2b_done_ready", cmd_ready, 1);
      step();
      chk("b2b_gap_valid", res_valid, 0);
      chk("b2b_second_loada_dados", dados, 4'b0110);
      chk("b2b_second_loada_sel21", sel21, 0);
      step();
      chk("b2b_mid1_valid", res_valid, 0);
      step();
      chk("b2b_mid2_valid", res_valid, 0);
      step();
      cmd_valid = 1'b0;
      chk("b2b_second_valid", res_valid, 1);
      chk("b2b_second_data", res_data, 4'b1100);
      chk("b2b_second_carry", res_carry, 0);
      step();
      chk("b2b_end_valid", res_valid, 0);
      chk("b2b_end_ready", cmd_ready, 1);

      // Asynchronous reset in the middle of EXEC
      res_ready = 1'b0;
      send(3'b010, 4'b0001, 4'b0001);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      chk("rst_mid_exec_op", operacao, 3'b010);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_mid_dados", dados, 0);
      chk("rst_mid_sel21", sel21, 1);
      chk("rst_mid_sel12", sel12, 0);
      chk("rst_mid_operacao", operacao, 0);
      chk("rst_mid_res_valid", res_valid, 0);
      chk("rst_mid_res_data", res_data, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_res_valid", res_valid, 0);
         chk("post_rst_sel21", sel21, 1);
      end

`ifdef DATAPATH_SEQ_ACCUM_EN
      // Accumulate: previous result 4, then A from feedback + 1
      res_ready = 1'b1;
      send(3'b010, 4'b0011, 4'b0001);
      step();
      cmd_valid = 1'b0;
      step();
      step();
      step();
      chk("acc_prev_data", res_data, 4'b0100);
      step();
      cmd_acc = 1'b1;
      send(3'b010, 4'b1010, 4'b0001);
      step();
      cmd_valid = 1'b0;
      cmd_acc   = 1'b0;
      chk("acc_loada_dados", dados, 0);
      chk("acc_loada_sel21", sel21, 1);
      chk("acc_loada_sel12", sel12, 0);
      step();
      step();
      step();
      chk("acc_res_valid", res_valid, 1);
      chk("acc_res_data", res_data, 4'b0101);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
